// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO: parametrised width/depth, programmable almost-full/empty margins, occupancy count, flush.
// Define FIFO_FWFT_EN for first-word-fall-through read data; otherwise data_out is registered with one-cycle latency.
module fifo_sync_prog #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 8,
   parameter int AF_MARGIN  = 1,
   parameter int AE_MARGIN  = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic [DATA_WIDTH-1:0]        data_in,
   input  logic                         wr_en,
   input  logic                         rd_en,
   output logic [DATA_WIDTH-1:0]        data_out,
   output logic                         wr_ack,
   output logic                         overflow,
   output logic                         underflow,
   output logic                         full,
   output logic                         empty,
   output logic                         almostfull,
   output logic                         almostempty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int                PTR_W    = $clog2(DEPTH);
   localparam int                CNT_W    = $clog2(DEPTH+1);
   localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH-1);
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]  AF_LEVEL = CNT_W'(DEPTH-AF_MARGIN);
   localparam logic [CNT_W-1:0]  AE_LEVEL = CNT_W'(AE_MARGIN);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
   logic [CNT_W-1:0]      count_q, count_nxt;
   logic                  wr_ok, rd_ok;

   // Pointers wrap by explicit compare so DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign count       = count_q;
   assign full        = (count_q == FULL_CNT);
   assign empty       = (count_q == '0);
   assign almostfull  = (count_q >= AF_LEVEL) && !full;
   assign almostempty = !empty && (count_q <= AE_LEVEL);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      wr_ok      = 1'b0;
      rd_ok      = 1'b0;
      wr_ptr_nxt = wr_ptr;
      rd_ptr_nxt = rd_ptr;
      count_nxt  = count_q;
      if (rst_n && !flush) begin
         wr_ok = wr_en && !full;
         rd_ok = rd_en && !empty;
      end
      if (wr_ok) wr_ptr_nxt = ptr_inc(wr_ptr);
      if (rd_ok) rd_ptr_nxt = ptr_inc(rd_ptr);
      unique case ({wr_ok, rd_ok})
         2'b10:   count_nxt = (count_q == FULL_CNT) ? count_q : count_q + 1'b1;
         2'b01:   count_nxt = (count_q == '0) ? count_q : count_q - 1'b1;
         default: count_nxt = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_q   <= '0;
         wr_ack    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         wr_ptr    <= wr_ptr_nxt;
         rd_ptr    <= rd_ptr_nxt;
         count_q   <= count_nxt;
         wr_ack    <= wr_ok;
         overflow  <= wr_en && full;
         underflow <= rd_en && empty;
      end
   end

   // NOTE: storage has no reset; stale entries are unreachable once the pointers and count clear.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= data_in;
   end

`ifdef FIFO_FWFT_EN
   // Head of queue is visible directly; zero while nothing is stored.
   assign data_out = empty ? '0 : mem[rd_ptr];
`else
   logic [DATA_WIDTH-1:0] data_out_q;

   always_ff @(posedge clk) begin
      if (!rst_n)     data_out_q <= '0;
      else if (rd_ok) data_out_q <= mem[rd_ptr];
   end

   assign data_out = data_out_q;
`endif

endmodule
